// File: rtl/fetch_unit.sv
// fetch_unit: rv32 instruction fetch with single-outstanding imem requests and redirect flush.
// Optional build macro FETCH_MISALIGN_EN: fault and park on misaligned redirect targets.
`default_nettype none

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_sel,
  input  logic [31:0] alu_target,
  input  logic        stall,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic        fetch_fault
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]  r_state, w_state_nxt;
  logic        r_drop, w_drop_nxt;
  logic [31:0] r_pc, r_hold_data, r_hold_pc;
  logic        w_slot_free, w_accept, w_park;
  logic        w_take_rsp, w_take_hold, w_to_hold;
  logic [31:0] w_target;

  assign w_slot_free = !inst_valid || !stall;
  assign w_accept    = imem_req_valid && imem_req_ready;

`ifdef FETCH_MISALIGN_EN
  logic r_fault;

  // A misaligned redirect parks the unit until an aligned redirect arrives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_fault <= 1'b0;
    else if (pc_sel) r_fault <= |alu_target[1:0];
  end

  assign w_park      = r_fault;
  assign w_target    = alu_target;
  assign fetch_fault = r_fault;
`else
  logic w_unused_tgt;

  assign w_unused_tgt = &{1'b0, alu_target[1:0]};
  assign w_park       = 1'b0;
  assign w_target     = {alu_target[31:2], 2'b00};
  assign fetch_fault  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_REQ;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_drop_nxt  = r_drop;
    w_take_rsp  = 1'b0;
    w_take_hold = 1'b0;
    w_to_hold   = 1'b0;
    if (pc_sel) begin
      case (r_state)
        S_REQ:  if (w_accept) begin
                  w_state_nxt = S_WAIT;
                  w_drop_nxt  = 1'b1;
                end
        S_WAIT: if (imem_rsp_valid) begin
                  w_state_nxt = S_REQ;
                  w_drop_nxt  = 1'b0;
                end else begin
                  w_drop_nxt  = 1'b1;
                end
        default: w_state_nxt = S_REQ;
      endcase
    end else begin
      case (r_state)
        S_REQ:  if (w_accept) w_state_nxt = S_WAIT;
        S_WAIT: if (imem_rsp_valid) begin
                  if (r_drop) begin
                    w_drop_nxt  = 1'b0;
                    w_state_nxt = S_REQ;
                  end else if (w_slot_free) begin
                    w_take_rsp  = 1'b1;
                    w_state_nxt = S_REQ;
                  end else begin
                    w_to_hold   = 1'b1;
                    w_state_nxt = S_HOLD;
                  end
                end
        S_HOLD: if (w_slot_free) begin
                  w_take_hold = 1'b1;
                  w_state_nxt = S_REQ;
                end
        default: w_state_nxt = S_REQ;
      endcase
    end
  end

  // Request channel decodes straight from state/PC; held low while in reset.
  always_comb begin
    imem_req_valid = rst && (r_state == S_REQ) && !w_park;
    imem_req_addr  = r_pc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc        <= RESET_PC;
      r_hold_data <= NOP;
      r_hold_pc   <= 32'h0;
      inst        <= NOP;
      inst_pc     <= 32'h0;
      inst_valid  <= 1'b0;
    end else if (pc_sel) begin
      r_pc       <= w_target;
      inst       <= NOP;
      inst_valid <= 1'b0;
    end else begin
      if (w_take_rsp || w_to_hold) r_pc <= r_pc + 32'd4;
      if (w_to_hold) begin
        r_hold_data <= imem_rsp_data;
        r_hold_pc   <= r_pc;
      end
      if (w_take_rsp) begin
        inst       <= imem_rsp_data;
        inst_pc    <= r_pc;
        inst_valid <= 1'b1;
      end else if (w_take_hold) begin
        inst       <= r_hold_data;
        inst_pc    <= r_hold_pc;
        inst_valid <= 1'b1;
      end else if (inst_valid && !stall) begin
        inst       <= NOP;
        inst_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
`default_nettype none

module tb_fetch_unit;

  localparam logic [31:0] C_NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_sel;
  logic [31:0] alu_target;
  logic        stall;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        fetch_fault;

  int n_cmp = 0;
  int n_err = 0;

  fetch_unit #(.RESET_PC(32'h0), .NOP(C_NOP)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_sel         (pc_sel),
    .alu_target     (alu_target),
    .stall          (stall),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_valid     (inst_valid),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request/response with 1-cycle memory latency, stall low.
  task automatic fetch_one(input logic [31:0] word, input logic [31:0] pc);
    chk("req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("req_addr", imem_req_addr, pc);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    chk("wait_no_req", {31'd0, imem_req_valid}, 32'd0);
    chk("slot_drained", {31'd0, inst_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = word;
    tick();
    imem_rsp_valid = 1'b0;
    chk("inst_valid", {31'd0, inst_valid}, 32'd1);
    chk("inst", inst, word);
    chk("inst_pc", inst_pc, pc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; pc_sel = 1'b0; alu_target = 32'h0; stall = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    repeat (2) tick();
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_inst", inst, C_NOP);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
    rst = 1'b1;
    #1;

    fetch_one(32'hA, 32'h0);
    fetch_one(32'hB, 32'h4);
    fetch_one(32'hC, 32'h8);

    for (int i = 0; i < 3; i++) begin
      chk("backpressure_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("backpressure_addr", imem_req_addr, 32'hC);
      tick();
    end
    fetch_one(32'hD, 32'hC);

    stall = 1'b1;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    chk("stall_keep_valid", {31'd0, inst_valid}, 32'd1);
    chk("stall_keep_inst", inst, 32'hD);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hE;
    tick();
    imem_rsp_valid = 1'b0;
    chk("hold_inst", inst, 32'hD);
    chk("hold_inst_pc", inst_pc, 32'hC);
    chk("hold_no_req", {31'd0, imem_req_valid}, 32'd0);
    tick();
    chk("hold_no_req2", {31'd0, imem_req_valid}, 32'd0);
    chk("hold_inst2", inst, 32'hD);
    stall = 1'b0;
    tick();
    chk("unhold_inst", inst, 32'hE);
    chk("unhold_inst_pc", inst_pc, 32'h10);
    chk("unhold_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("unhold_req_addr", imem_req_addr, 32'h14);

    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    pc_sel = 1'b1; alu_target = 32'h100;
    tick();
    pc_sel = 1'b0;
    chk("redir_wait_valid", {31'd0, inst_valid}, 32'd0);
    chk("redir_wait_noreq", {31'd0, imem_req_valid}, 32'd0);
    tick();
    chk("redir_wait_noreq2", {31'd0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD;
    tick();
    imem_rsp_valid = 1'b0;
    chk("drop_inst", inst, C_NOP);
    chk("drop_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("drop_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("drop_req_addr", imem_req_addr, 32'h100);
    fetch_one(32'h11, 32'h100);

    stall = 1'b1; pc_sel = 1'b1; alu_target = 32'h200;
    tick();
    stall = 1'b0; pc_sel = 1'b0;
    chk("redir_stall_valid", {31'd0, inst_valid}, 32'd0);
    chk("redir_stall_inst", inst, C_NOP);
    chk("redir_stall_req", {31'd0, imem_req_valid}, 32'd1);
    chk("redir_stall_addr", imem_req_addr, 32'h200);
    fetch_one(32'h22, 32'h200);

    imem_req_ready = 1'b1; pc_sel = 1'b1; alu_target = 32'h300;
    tick();
    imem_req_ready = 1'b0; pc_sel = 1'b0;
    chk("redir_acc_noreq", {31'd0, imem_req_valid}, 32'd0);
    chk("redir_acc_valid", {31'd0, inst_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD;
    tick();
    imem_rsp_valid = 1'b0;
    chk("redir_acc_drop", {31'd0, inst_valid}, 32'd0);
    chk("redir_acc_req", {31'd0, imem_req_valid}, 32'd1);
    chk("redir_acc_addr", imem_req_addr, 32'h300);

    pc_sel = 1'b1; alu_target = 32'h102;
    tick();
    pc_sel = 1'b0;
`ifdef FETCH_MISALIGN_EN
    chk("misalign_fault", {31'd0, fetch_fault}, 32'd1);
    chk("misalign_park", {31'd0, imem_req_valid}, 32'd0);
`else
    chk("misalign_fault", {31'd0, fetch_fault}, 32'd0);
    chk("misalign_req", {31'd0, imem_req_valid}, 32'd1);
    chk("misalign_addr", imem_req_addr, 32'h100);
`endif
    pc_sel = 1'b1; alu_target = 32'h200;
    tick();
    pc_sel = 1'b0;
    chk("realign_fault", {31'd0, fetch_fault}, 32'd0);
    chk("realign_req", {31'd0, imem_req_valid}, 32'd1);
    chk("realign_addr", imem_req_addr, 32'h200);

    pc_sel = 1'b1; alu_target = 32'hFFFF_FFFC;
    tick();
    pc_sel = 1'b0;
    fetch_one(32'h33, 32'hFFFF_FFFC);
    chk("wrap_addr", imem_req_addr, 32'h0);

    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    rst = 1'b0;
    #1;
    chk("async_rst_req", {31'd0, imem_req_valid}, 32'd0);
    chk("async_rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("async_rst_inst", inst, C_NOP);
    chk("async_rst_addr", imem_req_addr, 32'h0);
    tick();
    rst = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBEEF;
    #1;
    chk("post_rst_req", {31'd0, imem_req_valid}, 32'd1);
    tick();
    imem_rsp_valid = 1'b0;
    chk("post_rst_ignore", {31'd0, inst_valid}, 32'd0);
    chk("post_rst_req2", {31'd0, imem_req_valid}, 32'd1);
    chk("post_rst_addr", imem_req_addr, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the rv32 pipeline. It owns the program counter and issues single-outstanding requests to instruction memory over a valid/ready request channel. It presents each fetched word with its PC to the decode/control path, and accepts the control path's branch/jump redirect (`pc_sel` plus ALU target). Redirects flush in-flight and buffered instructions.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `NOP`, 32'h0000_0013, word driven on `inst` when `inst_valid`=0 (addi x0,x0,0)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-low
- `pc_sel`  in  1  redirect request from control; 1 = take `alu_target`
- `alu_target`  in  32  redirect target
- `stall`  in  1  decode cannot accept a new instruction this cycle
- `imem_req_valid`  out  1  fetch request valid
- `imem_req_ready`  in  1  memory accepts request
- `imem_req_addr`  out  32  fetch address (= internal PC)
- `imem_rsp_valid`  in  1  response data valid
- `imem_rsp_data`  in  32  fetched word
- `inst`  out  32  instruction to control/decode
- `inst_pc`  out  32  PC of `inst`
- `inst_valid`  out  1  `inst` is a live instruction
- `fetch_fault`  out  1  misaligned redirect fault (see Configuration)

## Operation
- States: REQ (request driven), WAIT (accepted, awaiting response), HOLD (response buffered, output slot busy).
- Output slot is free when `!inst_valid || !stall`. Slot is consumed on any cycle with `inst_valid`=1 and `stall`=0.
- REQ: `imem_req_valid`=1, `imem_req_addr`=PC.
  - On `imem_req_valid && imem_req_ready`, go to WAIT.
  - Address is held stable until accepted, except on redirect.
- WAIT: `imem_req_valid`=0. On `imem_rsp_valid`:
  - If the drop flag is set: discard the word, clear drop, go to REQ.
  - Else if the slot is free: `inst`←data, `inst_pc`←PC, `inst_valid`←1, PC←PC+4, go to REQ.
  - Else: capture data/PC in the hold register, PC←PC+4, go to HOLD.
- HOLD: when the slot frees, move hold register to output, go to REQ.
- If the slot is consumed and no new word is loaded in the same cycle, `inst_valid`←0.
- Redirect (`pc_sel`=1) has priority over everything, including `stall` and responses:
  - PC←target. `inst_valid`←0 next cycle. Hold register invalidated.
  - In REQ, not accepted this cycle: stay in REQ; the new address appears the next cycle.
  - In REQ, accepted this cycle: go to WAIT with drop set.
  - In WAIT without `imem_rsp_valid`: set drop.
  - In WAIT with `imem_rsp_valid`: discard the word, go to REQ.
  - In HOLD: go to REQ.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 wraps to 0.
- `imem_rsp_valid` outside WAIT is ignored.

## Timing
- Reset values:
  - `imem_req_valid`=0, `imem_req_addr`=`RESET_PC`.
  - `inst`=`NOP`, `inst_pc`=0, `inst_valid`=0, `fetch_fault`=0.
  - State REQ with PC=`RESET_PC`. Drop flag 0.
- First cycle after `rst` rises: `imem_req_valid`=1.
- All outputs are registered except `imem_req_valid`/`imem_req_addr`, which decode directly from state/PC.
- Memory response arrives ≥1 cycle after acceptance.
- Minimum latency: request accepted at cycle N, response at N+1, `inst_valid`=1 at N+2. Peak throughput is 1 instruction per 2 cycles.
- Reset mid-transaction: everything returns to reset values immediately. A response arriving later is ignored, because the unit is in REQ.

## Configuration
- `FETCH_MISALIGN_EN` defined:
  - A redirect with `alu_target[1:0]`≠0 sets `fetch_fault`=1 next cycle, flushes as normal, and parks the unit: no request is issued.
  - `fetch_fault` stays high until a redirect to an aligned target, which clears it and resumes fetching.
- `FETCH_MISALIGN_EN` undefined:
  - `alu_target[1:0]` is forced to 2'b00 on redirect.
  - `fetch_fault` is tied to 0.

## Test plan
- Reset release, memory always ready, 1-cycle response, words 0xA,0xB,0xC → `imem_req_addr` 0,4,8. `inst_valid` pulses with `inst_pc` 0,4,8 and `inst` 0xA,0xB,0xC, one instruction every 2 cycles.
- `imem_req_ready` held 0 for 3 cycles → `imem_req_valid`=1 with addr 0x0 stable for all 3 cycles. Accepted on the 4th.
- `stall`=1 with `inst_valid`=1 while the next response (0x4) arrives → unit enters HOLD, `inst` unchanged. When `stall` falls, `inst_pc`=0x4 next cycle. No request is issued while in HOLD.
- `pc_sel`=1, target 0x100, in WAIT; response 0xDEAD arrives 2 cycles later → 0xDEAD never appears on `inst`. Next request addr=0x100. `inst_valid`=0 the cycle after the redirect.
- `pc_sel` and `stall` together while `inst_valid`=1 → `inst_valid`=0 next cycle. Redirect fetch to target proceeds.
- With `FETCH_MISALIGN_EN`: redirect to 0x102 → `fetch_fault`=1, no request. Then redirect to 0x200 → `fetch_fault`=0, request addr 0x200. Without the macro: redirect to 0x102 → request addr 0x100.
